// File: rtl/jesd204_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jesd204_tx_pkg : shared types/constants for the JESD204 TX LMFC path |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package jesd204_tx_pkg;

  localparam int         OCT_PER_WORD = 4;
  localparam int         LMFC_CNT_W   = 11;
  localparam logic [3:0] MS_MASK      = 4'b0001;
  localparam logic [3:0] ME_MASK      = 4'b1000;

  typedef enum logic [2:0] {
    IDLE    = 3'b001,
    WAIT_SR = 3'b010,
    RUN     = 3'b100
  } lmfc_sm_t;

endpackage
`default_nettype wire

// File: rtl/tx_lmfc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tx_lmfc : LMFC generator, per-octet multiframe start/end markers     |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tx_lmfc
  import jesd204_tx_pkg::*;
#(
  parameter int OCTETS = OCT_PER_WORD,
  parameter int CNT_W  = LMFC_CNT_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              LMFC_EN,
  input  logic [2:0]        SUBCLASSV,
  input  logic [7:0]        CFG_F,
  input  logic [4:0]        CFG_K,
  input  logic              SYSREF,
  input  logic              SYSREF_REALIGN,
  output logic [OCTETS-1:0] LMFC_MS,
  output logic [OCTETS-1:0] LMFC_ME,
  output logic              LMFC_SYNCED,
  output logic              SYSREF_ERR,
  output logic              CFG_ERR
);

  lmfc_sm_t          state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  last_q;
  logic              sr_q, sr_qq;
  logic [OCTETS-1:0] ms_q, me_q;
  logic              synced_q, sref_err_q, cfg_err_q;

  // 14 bits so that F*K = 8192 still yields last_word = 2047
  logic [13:0]       w_mf_oct;
  logic [CNT_W-1:0]  w_last_word;
  logic              w_cfg_bad;
  logic              w_sr_edge;
  logic              w_at_last;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_hold_run;

  assign w_mf_oct    = ({6'd0, CFG_F} + 14'd1) * ({9'd0, CFG_K} + 14'd1);
  assign w_last_word = w_mf_oct[CNT_W+1:2] - CNT_W'(1);
  assign w_cfg_bad   = |w_mf_oct[1:0];
  assign w_sr_edge   = sr_q & ~sr_qq;
  assign w_at_last   = (cnt_q == last_q);
  assign w_cnt_inc   = w_at_last ? '0 : cnt_q + CNT_W'(1);
  assign w_hold_run  = (state_q == RUN) && (state_d == RUN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Both the live and the registered error block exit, so a bad
        // multiframe length can never be latched
        if (LMFC_EN && !w_cfg_bad && !cfg_err_q)
          state_d = (SUBCLASSV == 3'b000) ? RUN : WAIT_SR;
      end
      WAIT_SR: begin
        if (!LMFC_EN) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (w_sr_edge) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d   = w_cnt_inc;
        end
      end
      RUN: begin
        if (!LMFC_EN) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (w_sr_edge && !w_at_last && SYSREF_REALIGN) begin
          cnt_d   = '0;
        end else begin
          cnt_d   = w_cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_q     <= '0;
      sr_q       <= 1'b0;
      sr_qq      <= 1'b0;
      ms_q       <= '0;
      me_q       <= '0;
      synced_q   <= 1'b0;
      sref_err_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= SYSREF;
      sr_qq      <= sr_q;
      cfg_err_q  <= w_cfg_bad;
      if (state_q == IDLE)
        last_q <= w_last_word;
      // Outputs are qualified with the next state so they clear the
      // same cycle the FSM leaves RUN
      synced_q   <= w_hold_run;
      ms_q       <= (w_hold_run && (cnt_q == '0)) ? MS_MASK : '0;
      me_q       <= (w_hold_run && w_at_last)     ? ME_MASK : '0;
      sref_err_q <= w_hold_run && w_sr_edge && !w_at_last;
    end
  end

  assign LMFC_MS     = ms_q;
  assign LMFC_ME     = me_q;
  assign LMFC_SYNCED = synced_q;
  assign SYSREF_ERR  = sref_err_q;
  assign CFG_ERR     = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_lmfc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tx_lmfc : LMFC generator bench with a multiframe-phase model      |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_tx_lmfc;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] sub;
  logic [7:0] cfg_f;
  logic [4:0] cfg_k;
  logic       sysref;
  logic       realign;
  logic [3:0] ms, me;
  logic       synced, sref_err, cfg_err;

  tx_lmfc dut (
    .CLK            (clk),
    .RST            (rst),
    .LMFC_EN        (en),
    .SUBCLASSV      (sub),
    .CFG_F          (cfg_f),
    .CFG_K          (cfg_k),
    .SYSREF         (sysref),
    .SYSREF_REALIGN (realign),
    .LMFC_MS        (ms),
    .LMFC_ME        (me),
    .LMFC_SYNCED    (synced),
    .SYSREF_ERR     (sref_err),
    .CFG_ERR        (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference model: the link is idle, waiting for SYSREF, or running.
  // Multiframe phase is tracked as an anchor edge where a multiframe began
  // and a period P in words; word position = (edge - anchor) mod P.
  int   n_edge;
  int   mode;      // 0 idle, 1 waiting for SYSREF, 2 running
  int   anchor;
  int   per;
  bit   cfgerr_m;
  bit   s1, s2;
  logic [3:0] e_ms, e_me;
  bit   e_sync, e_err;

  function automatic int mod_p(int a, int p);
    return ((a % p) + p) % p;
  endfunction

  task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, n_edge, got, exp);
    end
  endtask

  task automatic model_update();
    int  mf, cur, nxt, pos;
    bit  bad, sredge, hold;
    n_edge++;
    if (rst) begin
      mode = 0; cfgerr_m = 0; s1 = 0; s2 = 0;
      e_ms = 4'h0; e_me = 4'h0; e_sync = 0; e_err = 0;
      return;
    end
    mf     = (int'(cfg_f) + 1) * (int'(cfg_k) + 1);
    bad    = (mf % 4) != 0;
    sredge = s1 && !s2;
    cur    = mode;
    nxt    = cur;
    pos    = (cur == 0) ? 0 : mod_p(n_edge - 1 - anchor, per);
    case (cur)
      0: if (en && !bad && !cfgerr_m) begin
           nxt    = (sub == 3'b000) ? 2 : 1;
           per    = mf / 4;
           anchor = n_edge;
         end
      1: if (!en) nxt = 0;
         else if (sredge) begin nxt = 2; anchor = n_edge; end
      default: if (!en) nxt = 0;
         else if (sredge && realign && pos != per - 1) anchor = n_edge;
    endcase
    hold     = (cur == 2) && (nxt == 2);
    e_ms     = (hold && pos == 0)       ? 4'b0001 : 4'b0000;
    e_me     = (hold && pos == per - 1) ? 4'b1000 : 4'b0000;
    e_sync   = hold;
    e_err    = hold && sredge && (pos != per - 1);
    cfgerr_m = bad;
    s2       = s1;
    s1       = sysref;
    mode     = nxt;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_val("ms",      32'(ms),       32'(e_ms));
    check_val("me",      32'(me),       32'(e_me));
    check_val("synced",  32'(synced),   32'(e_sync));
    check_val("sref_err",32'(sref_err), 32'(e_err));
    check_val("cfg_err", 32'(cfg_err),  32'(cfgerr_m));
  endtask

  // Pulse SYSREF so its edge is seen at word position target
  task automatic sysref_at(int target, int cycles, bit once);
    bit done;
    done = 0;
    for (int i = 0; i < cycles; i++) begin
      sysref = 1'b0;
      if (!done && mode != 0 && mod_p(n_edge + 1 - anchor, per) == target) begin
        sysref = 1'b1;
        done   = once;
      end
      step();
    end
    sysref = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0; n_edge = 0;
    mode = 0; anchor = 0; per = 1; cfgerr_m = 0; s1 = 0; s2 = 0;
    e_ms = 0; e_me = 0; e_sync = 0; e_err = 0;
    rst = 1'b1; en = 1'b0; sub = 3'b000; cfg_f = 8'd1; cfg_k = 5'd15;
    sysref = 1'b0; realign = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    // Subclass 0 free-running, 8-word multiframe
    en = 1'b1;
    repeat (30) step();
    en = 1'b0;
    repeat (2) step();

    // Subclass 1: no markers until a SYSREF edge
    sub = 3'b001; en = 1'b1;
    repeat (20) step();
    sysref = 1'b1; step();
    sysref = 1'b0;
    repeat (20) step();

    // Periodic SYSREF on multiframe boundaries
    sysref_at(per - 1, 40, 1'b0);
    // One shifted SYSREF, check-only then realigning
    realign = 1'b0;
    sysref_at((per - 1 + 3) % per, 20, 1'b1);
    realign = 1'b1;
    sysref_at((per - 1 + 3) % per, 20, 1'b1);

    // Held-high SYSREF across a re-enable gives no fresh edge
    en = 1'b0; sysref = 1'b1;
    repeat (3) step();
    en = 1'b1;
    repeat (10) step();
    sysref = 1'b0; repeat (2) step();
    sysref = 1'b1; step();
    sysref = 1'b0;
    repeat (15) step();

    // Reset mid-run
    rst = 1'b1; step();
    rst = 1'b0;
    repeat (5) step();

    // Bad configuration then a single-word multiframe
    en = 1'b0; step();
    sub = 3'b000; cfg_f = 8'd2; cfg_k = 5'd0; en = 1'b1;
    repeat (5) step();
    cfg_f = 8'd3;
    repeat (8) step();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 59) == 0) en = ~en;
      if ($urandom_range(0, 79) == 0) begin
        cfg_f   = 8'($urandom_range(0, 7));
        cfg_k   = 5'($urandom_range(0, 7));
        sub     = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
        realign = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 5) == 0) sysref = ~sysref;
      step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
